// File: rtl/ctrl_pkg.sv
// Shared definitions for the I2S controller.
// Holds the operating-mode codes, the transmit standard codes, the transmit
// sequencer state type and a helper that folds the reserved standard code.
package ctrl_pkg;

    // Operating modes: slave/master, transmit/receive.
    localparam logic [1:0] ST = 2'b00;
    localparam logic [1:0] SR = 2'b01;
    localparam logic [1:0] MT = 2'b10;
    localparam logic [1:0] MR = 2'b11;

    // Serial standards.
    localparam logic [1:0] I2S_STD = 2'b00;
    localparam logic [1:0] LJ_STD  = 2'b01;
    localparam logic [1:0] DSP_STD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } tx_state_t;

    // The reserved code 11 behaves as left-justified.
    function automatic logic [1:0] norm_std(input logic [1:0] std);
        return (std == 2'b11) ? LJ_STD : std;
    endfunction

endpackage

// File: rtl/i2s_tx_ctrl_clk_div.sv
// SCK generator for the I2S transmit sequencer.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   run        - divider enable; when low the counter and sck are held at 0
//   clk_div    - SCK half-period minus one, in clk cycles
//   sck        - registered serial bit clock
//   fall_tick  - high in the clk cycle whose edge drives sck 1->0
//   rise_tick  - high in the clk cycle whose edge drives sck 0->1
module i2s_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] clk_div,
    output logic             sck,
    output logic             fall_tick,
    output logic             rise_tick
);

    logic [DIV_W-1:0] count;
    logic             tick;

    assign tick      = run && (count == clk_div);
    assign fall_tick = tick && sck;
    assign rise_tick = tick && !sck;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
            sck   <= 1'b0;
        end else if (tick) begin
            count <= '0;
            sck   <= ~sck;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_ctrl.sv
// Master-mode I2S transmit sequencer.
// Pops words from a registered-read FIFO and shifts them out MSB-first on sd,
// generating sck and ws for the I2S, left-justified or DSP standard.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   en           - run request; dropping it stops at the end of the frame
//   mode         - operating mode; only MT runs the sequencer
//   standard     - serial standard (latched at start)
//   stereo       - 1: one word per slot, 0: one word per frame, sent twice
//   frame_size   - 0: 16-bit slots, 1: 32-bit slots (latched at start)
//   clk_div      - SCK half-period minus one
//   fifo_empty   - transmit FIFO empty
//   fifo_data    - FIFO read data, valid the clk after fifo_rd
//   fifo_rd      - one-clk pop strobe
//   sck, ws, sd  - serial outputs; ws_oe enables the ws driver
//   busy         - sequencer not idle
//   underflow    - sticky: a pop point found the FIFO empty
//   state        - current sequencer state, for observation
// FIFO handshake: fifo_rd is a single-cycle request issued only while
// fifo_empty is low; the word appears on fifo_data during the following clk.
module i2s_tx_ctrl
    import ctrl_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       standard,
    input  logic             stereo,
    input  logic             frame_size,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             fifo_empty,
    input  logic [31:0]      fifo_data,
    output logic             fifo_rd,
    output logic             sck,
    output logic             ws,
    output logic             ws_oe,
    output logic             sd,
    output logic             busy,
    output logic             underflow,
    output tx_state_t        state
);

    logic        fall_tick, rise_tick, run;
    logic [31:0] hold, shift, src, cur_word;
    logic [4:0]  bit_idx, n_max;
    logic [1:0]  std_q;
    logic        long_q, slot, cap, last_half;
    logic        last_bit, ws_next, stop_req;

    assign run = (state == RUN) || (state == DRAIN);

    i2s_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clk_div   (clk_div),
        .sck       (sck),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    always_comb begin
        n_max    = long_q ? 5'd31 : 5'd15;
        // A word popped at the previous slot end may still be in flight on
        // fifo_data when the next MSB is due (fast sck); bypass hold then.
        src      = cap ? fifo_data : hold;
        cur_word = (bit_idx == n_max) ? src : shift;
        last_bit = (bit_idx == 5'd0);
        stop_req = !en || (mode != MT);
        case (std_q)
            I2S_STD: ws_next = last_bit ? ~slot : slot;  // one bit early
            DSP_STD: ws_next = slot & last_bit;          // right-slot LSB only
            default: ws_next = ~slot;                    // LJ: high on left
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fifo_rd   <= 1'b0;
            ws        <= 1'b0;
            ws_oe     <= 1'b0;
            sd        <= 1'b0;
            busy      <= 1'b0;
            underflow <= 1'b0;
            hold      <= '0;
            shift     <= '0;
            bit_idx   <= '0;
            std_q     <= I2S_STD;
            long_q    <= 1'b0;
            slot      <= 1'b0;
            cap       <= 1'b0;
            last_half <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            // Registered-read FIFO: data is on fifo_data one clk after fifo_rd.
            if (fifo_rd) cap <= 1'b1;
            if (cap) begin
                hold <= fifo_data;
                cap  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (en && (mode == MT) && !fifo_empty) begin
                        state     <= PRIME;
                        fifo_rd   <= 1'b1;
                        busy      <= 1'b1;
                        ws_oe     <= 1'b1;
                        underflow <= 1'b0;
                        std_q     <= norm_std(standard);
                        long_q    <= frame_size;
                        bit_idx   <= frame_size ? 5'd31 : 5'd15;
                        slot      <= 1'b0;
                    end
                end
                PRIME: begin
                    if (cap) state <= RUN;
                end
                RUN: begin
                    if (fall_tick) begin
                        sd <= cur_word[bit_idx];
                        ws <= ws_next;
                        if (bit_idx == n_max) shift <= src;
                        if (last_bit) begin
                            bit_idx <= n_max;
                            slot    <= ~slot;
                            if (slot && stop_req) begin
                                state     <= DRAIN;
                                last_half <= 1'b0;
                            end else if (stereo || slot) begin
                                if (fifo_empty) begin
                                    underflow <= 1'b1;
                                    hold      <= '0;   // next slot sends zeros
                                end else begin
                                    fifo_rd <= 1'b1;
                                end
                            end
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Finish the LSB's high half, then stop on the next fall.
                    if (rise_tick) last_half <= 1'b1;
                    if (fall_tick && last_half) begin
                        state     <= IDLE;
                        sd        <= 1'b0;
                        ws        <= 1'b0;
                        busy      <= 1'b0;
                        ws_oe     <= 1'b0;
                        last_half <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
module tb_i2s_tx_ctrl;
    import ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, stereo, frame_size, fifo_empty;
    logic [1:0]  mode, standard;
    logic [7:0]  clk_div;
    logic [31:0] fifo_data;
    logic        fifo_rd, sck, ws, ws_oe, sd, busy, underflow;
    tx_state_t   state;

    i2s_tx_ctrl #(.DIV_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .standard(standard),
        .stereo(stereo), .frame_size(frame_size), .clk_div(clk_div),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .sck(sck), .ws(ws), .ws_oe(ws_oe), .sd(sd), .busy(busy),
        .underflow(underflow), .state(state)
    );

    // ---------------- FIFO model (registered read) ----------------
    logic [31:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic flush_req = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    initial fifo_data = '0;
    always @(posedge clk) begin
        if (flush_req) rd_ptr <= wr_ptr;
        else if (fifo_rd && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ---------------- monitor ----------------
    logic [1:0] obs_q[$];   // {ws, sd} per transmitted bit
    logic [1:0] exp_q[$];
    logic mon_clear = 1'b0;
    int pops, rd_empty, per_min, per_max, last_rise, cyc_cnt;
    logic prev_sck, seen_fall;
    initial begin
        cyc_cnt = 0; pops = 0; rd_empty = 0; per_min = 100000; per_max = 0;
        last_rise = -1; prev_sck = 1'b0; seen_fall = 1'b0;
    end
    always @(negedge clk) begin
        cyc_cnt++;
        if (mon_clear) begin
            obs_q.delete();
            pops = 0; rd_empty = 0; per_min = 100000; per_max = 0;
            last_rise = -1; prev_sck = 1'b0; seen_fall = 1'b0;
        end else begin
            if (fifo_rd) pops++;
            if (fifo_rd && fifo_empty) rd_empty++;
            if (!busy) seen_fall = 1'b0;
            if (sck && !prev_sck) begin
                if (seen_fall) obs_q.push_back({ws, sd});
                if (last_rise >= 0) begin
                    if (cyc_cnt - last_rise < per_min) per_min = cyc_cnt - last_rise;
                    if (cyc_cnt - last_rise > per_max) per_max = cyc_cnt - last_rise;
                end
                last_rise = cyc_cnt;
            end
            if (!sck && prev_sck) seen_fall = 1'b1;
            prev_sck = sck;
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        int bad;
        bad = -1;
        check({tag, " bit count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s stream bit %0d: got ws,sd=%b expected %b", tag, bad, obs_q[bad], exp_q[bad]);
        end
    endtask

    // ---------------- vectors and reference model ----------------
    typedef struct packed {
        logic [1:0]       std;
        logic             stereo;
        logic             fsz;
        logic [7:0]       div;
        int               nwords;
        int               frames;
        logic [5:0][31:0] words;
        int               exp_pops;
        logic             exp_uf;
    } vec_t;

    int   m_pops;
    logic m_uf;

    // Bit stream from the standard's rules: slot k/N, word per slot (stereo)
    // or per frame (mono), zeros once the words run out.
    task automatic build_model(input vec_t v);
        int n, slots, points, s, b, widx;
        logic [1:0] st;
        logic [31:0] w;
        logic r, nr, wsv;
        n      = v.fsz ? 32 : 16;
        slots  = 2 * v.frames;
        points = v.stereo ? slots - 1 : v.frames - 1;
        st     = (v.std == 2'b11) ? LJ_STD : v.std;
        m_pops = (points + 1 < v.nwords) ? points + 1 : v.nwords;
        m_uf   = (points + 1 > v.nwords);
        exp_q.delete();
        for (int k = 0; k < slots * n; k++) begin
            s    = k / n;
            b    = n - 1 - (k % n);
            widx = v.stereo ? s : s / 2;
            w    = (widx < v.nwords) ? v.words[widx] : 32'h0;
            r    = (s % 2) == 1;
            nr   = (((k + 1) / n) % 2) == 1;
            if (st == I2S_STD)      wsv = nr;
            else if (st == DSP_STD) wsv = r && (b == 0);
            else                    wsv = !r;
            exp_q.push_back({wsv, w[b]});
        end
    endtask

    task automatic clear_monitor();
        mon_clear = 1'b1;
        @(negedge clk);
        @(posedge clk);
        mon_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int exp_pops, input logic exp_uf);
        int n, thr, cyc;
        flush_fifo();
        clear_monitor();
        for (int i = 0; i < v.nwords; i++) begin
            mem[wr_ptr % 1024] = v.words[i];
            wr_ptr++;
        end
        build_model(v);
        standard = v.std; stereo = v.stereo; frame_size = v.fsz; clk_div = v.div;
        mode = MT; en = 1'b1;
        cyc = 0;
        while (!busy && cyc < 20) begin @(negedge clk); cyc++; end
        check({tag, " start busy"}, busy, 1);
        check({tag, " underflow cleared at start"}, underflow, 0);
        n   = v.fsz ? 32 : 16;
        thr = (v.frames - 1) * 2 * n + 3;
        cyc = 0;
        while (obs_q.size() < thr && cyc < 20000) begin @(negedge clk); cyc++; end
        check({tag, " reached stop point"}, obs_q.size() >= thr, 1);
        en = 1'b0;
        cyc = 0;
        while (busy && cyc < 20000) begin @(negedge clk); cyc++; end
        check({tag, " busy after stop"}, busy, 0);
        check({tag, " idle outputs sck,ws,sd,ws_oe"}, {sck, ws, sd, ws_oe}, 4'b0);
        check({tag, " state idle"}, state, IDLE);
        check({tag, " fifo_rd count"}, pops, exp_pops);
        check({tag, " underflow"}, underflow, exp_uf);
        check({tag, " pop while empty"}, rd_empty, 0);
        check({tag, " sck period min"}, per_min, 2 * (v.div + 1));
        check({tag, " sck period max"}, per_max, 2 * (v.div + 1));
        check_stream(tag);
    endtask

    function automatic vec_t mk(input logic [1:0] std, input logic st, input logic fsz,
                                input logic [7:0] div, input int nw, input int fr,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int ep, input logic eu);
        vec_t v;
        v = '0;
        v.std = std; v.stereo = st; v.fsz = fsz; v.div = div;
        v.nwords = nw; v.frames = fr;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
        v.exp_pops = ep; v.exp_uf = eu;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    vec_t tbl [6];
    vec_t rv;

    initial begin
        tbl[0] = mk(I2S_STD, 1, 0, 1, 2, 1, 32'hA5F0, 32'h0F5A, 0, 2, 0);
        tbl[1] = mk(LJ_STD,  1, 0, 1, 2, 1, 32'hA5F0, 32'h0F5A, 0, 2, 0);
        tbl[2] = mk(DSP_STD, 0, 1, 0, 2, 2, 32'h80000001, 32'h80000001, 0, 2, 0);
        tbl[3] = mk(I2S_STD, 1, 0, 1, 1, 1, 32'hA5F0, 0, 0, 1, 1);
        tbl[4] = mk(LJ_STD,  1, 0, 2, 3, 2, 32'h1234, 32'h5678, 32'h9ABC, 3, 1);
        tbl[5] = mk(2'b11,   0, 0, 0, 2, 2, 32'hCAFE, 32'hBEEF, 0, 2, 0);

        rst = 1'b1; en = 1'b0; mode = ST; standard = I2S_STD;
        stereo = 1'b1; frame_size = 1'b0; clk_div = 8'd1;
        repeat (3) @(negedge clk);
        check("reset outputs", {sck, ws, ws_oe, sd, fifo_rd, busy, underflow}, 7'b0);
        check("reset state", state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i), tbl[i].exp_pops, tbl[i].exp_uf);

        for (int i = 0; i < 16; i++) begin
            rv = '0;
            rv.std    = 2'($urandom_range(0, 3));
            rv.stereo = 1'($urandom_range(0, 1));
            rv.fsz    = 1'($urandom_range(0, 1));
            rv.div    = 8'($urandom_range(0, 3));
            rv.nwords = $urandom_range(1, 6);
            rv.frames = $urandom_range(1, 3);
            for (int j = 0; j < 6; j++) rv.words[j] = $urandom;
            build_model(rv);
            run_vec(rv, $sformatf("rand%0d", i), m_pops, m_uf);
        end

        // Reset in the middle of a word aborts at once.
        flush_fifo();
        for (int i = 0; i < 4; i++) begin mem[wr_ptr % 1024] = $urandom; wr_ptr++; end
        standard = I2S_STD; stereo = 1'b1; frame_size = 1'b0; clk_div = 8'd1;
        mode = MT; en = 1'b1;
        repeat (60) @(negedge clk);
        check("mid-run busy before rst", busy, 1);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        check("rst outputs", {sck, ws, ws_oe, sd, fifo_rd, busy, underflow}, 7'b0);
        check("rst state", state, IDLE);
        rst = 1'b0;
        clear_monitor();
        repeat (40) @(negedge clk);
        check("pops after rst", pops, 0);
        check("busy after rst", busy, 0);

        // Non-master mode never starts.
        flush_fifo();
        for (int i = 0; i < 2; i++) begin mem[wr_ptr % 1024] = $urandom; wr_ptr++; end
        clear_monitor();
        mode = ST; en = 1'b1;
        repeat (60) @(negedge clk);
        check("mode ST busy", busy, 0);
        check("mode ST ws_oe", ws_oe, 0);
        check("mode ST pops", pops, 0);
        en = 1'b0;
        flush_fifo();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_ctrl.md
Name: i2s_tx_ctrl

Overview:
Master-mode transmit sequencer for the I2S transmit path.
- Divides the system clock into SCK and generates WS for the selected standard.
- Pops words from the transmit FIFO (registered read, 1-cycle latency) and serialises them MSB-first on SD.
- Handles start, graceful stop at a frame boundary, and FIFO underflow.
- Only active when mode==MT; in all other modes it stays idle with WS released.

Parameters:
DIV_W, 8, width of the clock-divider setting clk_div.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run request; 1 = start/continue, 0 = stop after current frame
mode  in  2  ctrl_pkg mode; only MT enables operation
standard  in  2  ctrl_pkg standard: I2S_STD(00), LJ_STD(01), DSP_STD(10); 11 treated as LJ_STD
stereo  in  1  1 = independent L/R words; 0 = mono, same word in both slots
frame_size  in  1  0 = 16-bit slot, 1 = 32-bit slot
clk_div  in  DIV_W  SCK half-period = clk_div+1 clk cycles
fifo_empty  in  1  transmit FIFO empty
fifo_data  in  32  FIFO read data, valid the clk after fifo_rd
fifo_rd  out  1  one-clk pop strobe
sck  out  1  serial bit clock
ws  out  1  word select
ws_oe  out  1  WS output enable (1 while not IDLE)
sd  out  1  serial data
busy  out  1  state != IDLE
underflow  out  1  sticky underflow flag

Behaviour:
- Reset (synchronous): sck=0, ws=0, ws_oe=0, sd=0, fifo_rd=0, busy=0, underflow=0, state=IDLE, divider=0.
- All outputs are registered.
- Divider: counter runs while not IDLE; tick when count==clk_div, then count=0.
  - sck toggles on each tick.
  - A "fall" tick (sck 1->0) updates sd, ws and the bit index.
- Slot length N = 16 (frame_size=0) or 32; bits [N-1:0] of the word are used.
- standard and frame_size are latched on the IDLE->PRIME transition; changes while running are ignored.
- States:
  - IDLE: leaves to PRIME when en && mode==MT && !fifo_empty, popping the first word. Empty FIFO keeps it in IDLE and does not set underflow.
  - PRIME: captures fifo_data into the hold register one clk after the pop. Moves to RUN with the divider starting; sck is 0 at entry.
  - RUN: on each fall tick, sd drives shift[bit_idx] and bit_idx decrements from N-1.
    - At bit_idx==N-1 the hold register is transferred into shift, so the MSB goes out on the first fall tick of each slot.
    - The slot toggles L->R->L when bit_idx wraps from 0 to N-1.
  - DRAIN: entered from RUN when en==0 or mode!=MT is seen during the right slot LSB. Completes that final fall/rise half-periods, then goes to IDLE with sck=0, ws=0, sd=0.
- WS:
  - I2S_STD: left slot ws=0, right ws=1. ws changes on the fall tick driving the previous slot's LSB, i.e. one bit before the MSB.
  - LJ_STD: left ws=1, right ws=0. ws changes together with the MSB.
  - DSP_STD: ws=1 only during the fall-tick period carrying the right-slot LSB (first frame: none), else 0.
- Pop scheduling: fifo_rd pulses one clk after a fall tick that drives bit_idx 0.
  - stereo=1: pops at the end of every slot.
  - stereo=0: pops only at the end of the right slot; the left word is reused for the right slot.
  - No pop is issued when a stop is pending.
- Underflow: if fifo_empty at a pop point, there is no pop and underflow is set (sticky). The next slot transmits zeros; ws continues normally.
  - underflow is cleared by rst or by an IDLE->PRIME start.
- rst mid-frame aborts immediately to reset values; no further pops.

Decomposition:
- ctrl_pkg gains the standard constants I2S_STD/LJ_STD/DSP_STD and a tx_state_t enum {IDLE, PRIME, RUN, DRAIN}; mode constants MT/ST stay there.
- One natural sub-module: i2s_clk_div, the divider producing sck, fall_tick and rise_tick from clk_div and run.

Test Plan:
1. mode=MT, I2S_STD, stereo=1, frame_size=0, clk_div=1, FIFO {0xA5F0, 0x0F5A}, en held high:
   - sck period 4 clk.
   - sd left = A5F0 MSB-first, then 0F5A.
   - ws rises on the fall tick carrying left bit0.
   - Exactly 2 fifo_rd pulses in the frame.
2. Same as scenario 1 with LJ_STD: ws=1 during the 16 left bits, 0 during the 16 right bits; ws and MSB edges coincide.
3. Mono, frame_size=1, word 0x80000001, DSP_STD:
   - Both slots carry 0x80000001.
   - One fifo_rd per 64 sck.
   - ws pulses high for exactly 1 sck period at each right-slot LSB.
4. FIFO holds 1 word in stereo:
   - The right slot transmits 16 zeros.
   - underflow=1 and stays 1.
   - No fifo_rd while fifo_empty.
   - A restart from IDLE clears underflow.
5. en dropped mid left slot:
   - The right slot completes, then IDLE.
   - sck/ws/sd/busy/ws_oe all 0.
   - No pop after the stop.
6. rst asserted mid-word, and mode=ST with en=1:
   - rst returns all outputs to reset values on the next clk.
   - mode=ST with en=1: block remains IDLE, ws_oe=0, no fifo_rd.
